// File: rtl/nn_pkg.sv
// ============================================================================
// Module : nn_pkg
// Shared types and requantization constants for the neuron datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int NN_WIDTH = 8;
  localparam int NN_IFR   = 4;
  localparam int NN_OFR   = 5;

  function automatic int rnd_const(input int d);
    return (d > 0) ? (1 << ((d > 0) ? d - 1 : 0)) : 0;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int D       = NN_OFR - NN_IFR;
  localparam int RND     = rnd_const(D);
  localparam int SAT_MAX = sat_max(NN_WIDTH);
  localparam int SAT_MIN = sat_min(NN_WIDTH);

endpackage

`default_nettype wire

// File: rtl/neuron_accum_requant_sat.sv
// ============================================================================
// Module : requant_sat
// Combinational shift / round-half-up / optional ReLU (NEURON_ACCUM_RELU_EN) /
// saturate from an AWIDTH accumulator down to a WIDTH activation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module requant_sat
  import nn_pkg::*;
#(
  parameter int WIDTH  = NN_WIDTH,
  parameter int AWIDTH = 24,
  parameter int SHIFT  = D
) (
  input  logic signed [AWIDTH-1:0] acc,
  output logic        [WIDTH-1:0]  y_next,
  output logic                     clamp
);

  // One guard bit for the rounding add, plus room for a left shift.
  localparam int SH = (SHIFT < 0) ? -SHIFT : 0;
  localparam int EW = AWIDTH + 1 + SH;

  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(WIDTH));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(WIDTH));
  localparam logic [WIDTH-1:0] YMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] YMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;
  logic signed [EW-1:0] relu_v;

  assign ext = EW'(acc);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EW-1:0] RV = EW'(rnd_const(SHIFT));
      assign shifted = (ext + RV) >>> SHIFT;
    end else if (SHIFT < 0) begin : g_lshift
      assign shifted = ext <<< SH;
    end else begin : g_pass
      assign shifted = ext;
    end
  endgenerate

`ifdef NEURON_ACCUM_RELU_EN
  assign relu_v = shifted[EW-1] ? '0 : shifted;
`else
  assign relu_v = shifted;
`endif

  always_comb begin
    clamp  = 1'b0;
    y_next = relu_v[WIDTH-1:0];
    if (relu_v > MAXV) begin
      y_next = YMAX;
      clamp  = 1'b1;
    end else if (relu_v < MINV) begin
      y_next = YMIN;
      clamp  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_accum.sv
// ============================================================================
// Module : neuron_accum
// Accumulates macfp partial sums on a bias, then requantizes to one activation.
// Optional ReLU via NEURON_ACCUM_RELU_EN. Rev : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_accum
  import nn_pkg::*;
#(
  parameter int WIDTH  = NN_WIDTH,
  parameter int IFR    = NN_IFR,
  parameter int OFR    = NN_OFR,
  parameter int CW     = 8,
  parameter int AWIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ack,
  input  logic [CW-1:0]        nchunks,
  input  logic [2*WIDTH-1:0]   bias,
  input  logic [2*WIDTH-1:0]   mac_acc,
  input  logic                 mac_done,
  output logic [WIDTH-1:0]     y,
  output logic                 done,
  output logic                 busy,
  output logic                 ovf
);

  generate
    if (AWIDTH < 2*WIDTH + CW) begin : g_awidth_chk
      $error("neuron_accum: AWIDTH must be >= 2*WIDTH+CW");
    end
  endgenerate

  state_t                    state;
  logic signed [AWIDTH-1:0]  acc;
  logic        [CW-1:0]      count;
  logic signed [AWIDTH-1:0]  bias_ext;
  logic signed [AWIDTH-1:0]  part_ext;
  logic        [WIDTH-1:0]   y_next;
  logic                      clamp;

  assign bias_ext = AWIDTH'($signed(bias));
  assign part_ext = AWIDTH'($signed(mac_acc));
  assign busy     = (state != IDLE);

  requant_sat #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH),
    .SHIFT  (OFR - IFR)
  ) u_requant (
    .acc    (acc),
    .y_next (y_next),
    .clamp  (clamp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      y     <= '0;
      ack   <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            count <= nchunks;
            ovf   <= 1'b0;
            ack   <= 1'b1;
            state <= (nchunks != '0) ? ACCUM : FINAL;
          end
        end
        ACCUM: begin
          if (mac_done) begin
            acc   <= acc + part_ext;
            count <= count - 1'b1;
            if (count == CW'(1)) state <= FINAL;
          end
        end
        FINAL: begin
          y     <= y_next;
          if (clamp) ovf <= 1'b1;
          done  <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
